// File: rtl/dest_demux_d0d1_pkg.sv
// Shared definitions for the D0/D1 destination demultiplexer.
// Holds the FSM state encoding and the destination-bit meaning.
package dest_demux_d0d1_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/dest_demux_d0d1.sv
// Pops words from the VC-arbiter output FIFO and steers each to the D0 or D1 egress FIFO,
// throttling on the target's almost_full and counting words written per destination.
module dest_demux_d0d1
  import dest_demux_d0d1_pkg::*;
#(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [BW-1:0]    src_data_in,
  input  logic             src_empty,
  output logic             src_rd,
  input  logic             D0_almost_full,
  input  logic             D1_almost_full,
  input  logic             D0_full,
  input  logic             D1_full,
  output logic             D0_wr,
  output logic             D1_wr,
  output logic [BW-1:0]    D_data_out,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic             idle_out,
  output logic             error_out
);

  state_t state, next_state;
  logic   dest;
  logic   af;
  logic   clr;

  assign dest     = src_data_in[DEST_BIT];
  assign af       = (dest == DEST_D1) ? D1_almost_full : D0_almost_full;
  // Pop straight from IDLE so the first word of a burst costs no bubble.
  assign src_rd   = ((state == ST_IDLE) || (state == ST_ACTIVE)) & ~src_empty & ~af & ~init;
  assign idle_out = (state == ST_IDLE);
  // Clearing on init itself (not only in INIT) drops the trailing write from the count.
  assign clr      = init | (state == ST_INIT);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_RESET;
    else          state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (init) begin
      next_state = ST_INIT;
    end else begin
      case (state)
        ST_RESET:  next_state = ST_INIT;
        ST_INIT:   next_state = ST_IDLE;
        ST_IDLE:   if (!src_empty) next_state = ST_ACTIVE;
        ST_ACTIVE: if (src_empty && !D0_wr && !D1_wr) next_state = ST_IDLE;
        default:   next_state = ST_RESET;
      endcase
    end
  end

  // Data register holds its last value when nothing is popped.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      D0_wr      <= 1'b0;
      D1_wr      <= 1'b0;
      D_data_out <= '0;
    end else if (src_rd) begin
      D0_wr      <= (dest == DEST_D0);
      D1_wr      <= (dest == DEST_D1);
      D_data_out <= src_data_in;
    end else begin
      D0_wr      <= 1'b0;
      D1_wr      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_D0    <= '0;
      cnt_D1    <= '0;
      error_out <= 1'b0;
    end else if (clr) begin
      cnt_D0    <= '0;
      cnt_D1    <= '0;
      error_out <= 1'b0;
    end else begin
      if (D0_wr) cnt_D0 <= cnt_D0 + CNT_W'(1);
      if (D1_wr) cnt_D1 <= cnt_D1 + CNT_W'(1);
      // Writing into a full FIFO means the almost_full threshold is misconfigured.
      if ((D0_wr && D0_full) || (D1_wr && D1_full)) error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dest_demux_d0d1.sv
// Directed bench for dest_demux_d0d1: a queue stands in for the upstream
// first-word-fall-through FIFO; each scenario task checks its own expectations.
module tb_dest_demux_d0d1;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [5:0] src_data_in;
  logic       src_empty;
  logic       src_rd;
  logic       D0_almost_full, D1_almost_full, D0_full, D1_full;
  logic       D0_wr, D1_wr;
  logic [5:0] D_data_out;
  logic [4:0] cnt_D0, cnt_D1;
  logic       idle_out, error_out;

  int checks = 0;
  int errors = 0;
  logic [5:0] q[$];

  always #5 clk = ~clk;

  dest_demux_d0d1 #(.BW(6), .DEST_BIT(4), .CNT_W(5)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .src_data_in(src_data_in), .src_empty(src_empty), .src_rd(src_rd),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .D0_full(D0_full), .D1_full(D1_full),
    .D0_wr(D0_wr), .D1_wr(D1_wr), .D_data_out(D_data_out),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
    .idle_out(idle_out), .error_out(error_out)
  );

  task automatic refresh();
    src_empty   = (q.size() == 0);
    src_data_in = (q.size() != 0) ? q[0] : 6'h00;
    #1;
  endtask

  task automatic push(input logic [5:0] w);
    q.push_back(w);
    refresh();
  endtask

  // Advance one clock; the model pops its head when the DUT popped at the edge.
  task automatic tick();
    logic popped;
    @(negedge clk);
    popped = src_rd;
    @(posedge clk);
    #1;
    if (popped && q.size() != 0) void'(q.pop_front());
    refresh();
  endtask

  task automatic expect_out(input string name, input logic e_d0, input logic e_d1,
                            input logic [5:0] e_data, input logic [4:0] e_c0,
                            input logic [4:0] e_c1);
    checks++;
    if ({D0_wr, D1_wr, D_data_out, cnt_D0, cnt_D1} !== {e_d0, e_d1, e_data, e_c0, e_c1}) begin
      errors++;
      $display("FAIL %s: got wr0=%b wr1=%b data=%h c0=%0d c1=%0d, expected wr0=%b wr1=%b data=%h c0=%0d c1=%0d",
               name, D0_wr, D1_wr, D_data_out, cnt_D0, cnt_D1, e_d0, e_d1, e_data, e_c0, e_c1);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0; init = 1'b0;
    D0_almost_full = 0; D1_almost_full = 0; D0_full = 0; D1_full = 0;
    refresh();
    @(posedge clk); #1;
    expect_out("reset_outputs", 0, 0, 6'h00, 5'd0, 5'd0);
    expect_bit("reset_idle", idle_out, 1'b0);
    expect_bit("reset_error", error_out, 1'b0);
    expect_bit("reset_src_rd", src_rd, 1'b0);
    @(negedge clk);
    reset_L = 1'b1; init = 1'b1;
    repeat (3) tick();
    push(6'h05);
    expect_bit("init_src_rd_held", src_rd, 1'b0);
    expect_bit("init_idle", idle_out, 1'b0);
    expect_out("init_outputs", 0, 0, 6'h00, 5'd0, 5'd0);
    void'(q.pop_front());
    refresh();
    init = 1'b0;
    tick();
    expect_bit("idle_after_init", idle_out, 1'b1);
  endtask

  task automatic test_routing();
    push(6'h05);
    push(6'h15);
    expect_bit("route_pop_from_idle", src_rd, 1'b1);
    tick();
    expect_out("route_d0_word", 1, 0, 6'h05, 5'd0, 5'd0);
    tick();
    expect_out("route_d1_word", 0, 1, 6'h15, 5'd1, 5'd0);
    tick();
    expect_out("route_counts", 0, 0, 6'h15, 5'd1, 5'd1);
    expect_bit("route_active_while_pending", idle_out, 1'b0);
    tick();
    expect_bit("route_back_to_idle", idle_out, 1'b1);
  endtask

  task automatic test_throttle();
    D0_almost_full = 1'b1;
    push(6'h03);
    expect_bit("throttle_no_pop", src_rd, 1'b0);
    repeat (2) tick();
    expect_out("throttle_no_write", 0, 0, 6'h15, 5'd1, 5'd1);
    D0_almost_full = 1'b0;
    #1;
    expect_bit("throttle_release_pop", src_rd, 1'b1);
    tick();
    expect_out("throttle_release_write", 1, 0, 6'h03, 5'd1, 5'd1);
    tick();
    expect_out("throttle_count", 0, 0, 6'h03, 5'd2, 5'd1);
  endtask

  task automatic test_head_of_line();
    D1_almost_full = 1'b1;
    push(6'h1A);
    push(6'h0B);
    expect_bit("hol_no_pop", src_rd, 1'b0);
    repeat (2) tick();
    expect_out("hol_no_write", 0, 0, 6'h03, 5'd2, 5'd1);
    checks++;
    if (q.size() !== 2) begin
      errors++;
      $display("FAIL hol_queue_depth: got %0d expected 2", q.size());
    end
    D1_almost_full = 1'b0;
    tick();
    expect_out("hol_d1_first", 0, 1, 6'h1A, 5'd2, 5'd1);
    tick();
    expect_out("hol_d0_second", 1, 0, 6'h0B, 5'd2, 5'd2);
    tick();
    expect_out("hol_counts", 0, 0, 6'h0B, 5'd3, 5'd2);
  endtask

  task automatic test_wrap_error();
    int writes;
    logic [5:0] exp_word;
    init = 1'b1;
    tick();
    expect_out("wrap_cleared", 0, 0, 6'h0B, 5'd0, 5'd0);
    init = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) q.push_back({i[4], 1'b0, i[3:0]});
    refresh();
    writes = 0;
    for (int t = 0; t < 40 && writes < 32; t++) begin
      tick();
      if (D0_wr) begin
        exp_word = {writes[4], 1'b0, writes[3:0]};
        checks++;
        if (D_data_out !== exp_word || D1_wr !== 1'b0) begin
          errors++;
          $display("FAIL wrap_word_%0d: got %h/wr1=%b expected %h/wr1=0",
                   writes, D_data_out, D1_wr, exp_word);
        end
        writes++;
      end
    end
    tick();
    checks++;
    if (writes !== 32) begin
      errors++;
      $display("FAIL wrap_write_count: got %0d expected 32", writes);
    end
    expect_out("wrap_counter_zero", 0, 0, 6'h2F, 5'd0, 5'd0);
    push(6'h02);
    expect_bit("error_clear_before", error_out, 1'b0);
    D1_full = 1'b1;
    tick();
    D1_full = 1'b0;
    D0_full = 1'b1;
    #1;
    expect_bit("error_d0_wr_now", D0_wr, 1'b1);
    tick();
    D0_full = 1'b0;
    expect_bit("error_set", error_out, 1'b1);
    repeat (2) tick();
    expect_bit("error_sticky", error_out, 1'b1);
    init = 1'b1;
    tick();
    expect_bit("error_cleared_by_init", error_out, 1'b0);
    expect_out("error_init_counts", 0, 0, 6'h02, 5'd0, 5'd0);
    init = 1'b0;
    tick();
  endtask

  task automatic test_mid_init();
    int guard;
    q.push_back(6'h01); q.push_back(6'h11); q.push_back(6'h02);
    q.push_back(6'h12); q.push_back(6'h03); q.push_back(6'h13);
    refresh();
    tick();
    tick();
    expect_out("mid_stream_flow", 0, 1, 6'h11, 5'd1, 5'd0);
    init = 1'b1;
    #1;
    expect_bit("mid_init_src_rd_drop", src_rd, 1'b0);
    tick();
    expect_out("mid_init_cleared", 0, 0, 6'h11, 5'd0, 5'd0);
    checks++;
    if (q.size() !== 4) begin
      errors++;
      $display("FAIL mid_init_queue_depth: got %0d expected 4", q.size());
    end
    init = 1'b0;
    tick();
    guard = 0;
    while ((q.size() != 0 || D0_wr || D1_wr) && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL mid_init_drain: timeout with %0d words left", q.size());
    end
    expect_out("mid_init_resumed_counts", 0, 0, 6'h13, 5'd2, 5'd2);
  endtask

  task automatic test_async_reset();
    push(6'h14);
    push(6'h04);
    tick();
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    expect_out("async_reset_outputs", 0, 0, 6'h00, 5'd0, 5'd0);
    expect_bit("async_reset_src_rd", src_rd, 1'b0);
  endtask

  initial begin
    test_reset();
    test_routing();
    test_throttle();
    test_head_of_line();
    test_wrap_error();
    test_mid_init();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
